buzzer_sequencer: RTL and testbench
===================================

Name: buzzer_sequencer

Overview:
Parametrised buzzer pattern generator for the calculator game. It replaces fixed per-state buzz timings with a table of NUM_PATTERNS selectable sound patterns. Each pattern is REPEATS bursts of toggled or steady tone, separated by silent gaps. It is started by a start/pattern handshake from the game FSM and reports busy, done and abort status back to it.

Parameters:
NUM_PATTERNS, 4, number of selectable patterns (>=1)
PAT_W, 2, width of pattern index (>= clog2(NUM_PATTERNS), min 1)
CNT_W, 16, width of all internal timing counters and table entries
HALF_TBL, {16'd2,16'd0,16'd3,16'd1}, packed per-pattern half-period in ticks (entry i at [i*CNT_W +: CNT_W]); 0 = steady high
TONE_TBL, {16'd6,16'd14,16'd12,16'd10}, packed per-pattern tone length per burst in ticks
GAP_TBL, {16'd6,16'd0,16'd0,16'd0}, packed per-pattern silent gap between bursts in ticks
REP_TBL, {16'd3,16'd1,16'd1,16'd1}, packed per-pattern burst count
RETRIGGER, 0, 1 = start while busy restarts with the new pattern; 0 = start while busy is ignored
DONE_PULSE, 0, 0 = buzz_done held until next accepted start or abort; 1 = buzz_done is a one-tick pulse

Ports:
tick  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request to play a pattern, sampled each tick
pattern  input  PAT_W  pattern index, sampled with start
abort  input  1  stop immediately, no completion reported
buzz  output  1  buzzer drive, registered
busy  output  1  high in TONE or GAP
buzz_done  output  1  pattern completed
active_pat  output  PAT_W  index of the pattern playing or last played

Behaviour:
- Reset (async): state IDLE; buzz=0, busy=0, buzz_done=0, active_pat=0; all counters 0.
- States: IDLE, TONE, GAP, DONE. busy = (TONE|GAP).
- Accept rule: start=1 with pattern<NUM_PATTERNS, and state IDLE/DONE (or any state if RETRIGGER=1). An out-of-range index is ignored with no state change.
- On accept: latch table entries; active_pat<=pattern; burst counter<=1; tone counter<=0; phase<=0; buzz<=1; buzz_done<=0; next state TONE. buzz is high on the first tick after the start edge, so latency is 1 tick.
- Normalisation at latch: TONE=0 is treated as 1; REP=0 is treated as 1.
- TONE, per tick:
  - tone counter++ and phase++.
  - If HALF>0 and phase reaches HALF: buzz toggles and phase<=0. With HALF=1, buzz toggles every tick.
  - If HALF=0: buzz stays 1.
- End of burst, when tone counter reaches TONE:
  - buzz<=0.
  - Last burst: go to DONE.
  - Otherwise, GAP>0: go to GAP.
  - Otherwise (GAP=0): start the next burst in TONE directly with buzz<=1 and counters cleared. buzz is therefore low for exactly 1 tick between back-to-back bursts.
- GAP: buzz=0. Count GAP ticks, then burst counter++, buzz<=1, go to TONE.
- DONE:
  - buzz_done<=1 on entry.
  - DONE_PULSE=1: buzz_done drops the next tick and the FSM returns to IDLE.
  - DONE_PULSE=0: the FSM stays in DONE with buzz_done high until the next accepted start or abort.
- abort=1: next tick goes to IDLE with buzz=0, buzz_done=0; counters are cleared. abort has priority over start in the same tick.
- Completion and start in the same tick with RETRIGGER=1: start wins, buzz_done is not asserted.
- Counter arithmetic is CNT_W unsigned. Tables must hold values < 2^CNT_W; no wrap occurs because counters compare for equality before incrementing past the limit.
- reset mid-pattern: buzz falls asynchronously and immediately.

Decomposition:
- Shared package buzzer_pkg holds:
  - state encoding constants (IDLE/TONE/GAP/DONE);
  - the default pattern index constants PAT_OK=0, PAT_ERR=1, PAT_OVER=2, PAT_ALERT=3, so the game FSM names patterns, not numbers.
- One natural sub-module: buzzer_tone_gen (phase counter plus toggle, inputs half-period/enable/clear, output tone). It is reused for future multi-channel variants.

Test Plan:
- reset mid-TONE of pattern 0 -> buzz, busy, buzz_done go 0 immediately. After release, the FSM is IDLE and a start works normally.
- start with pattern=0 (HALF=1, TONE=10, REP=1) -> buzz toggles every tick for 10 ticks starting high. It then goes 0 and buzz_done rises at tick 11 and stays high (DONE_PULSE=0).
- pattern=2 (HALF=0, TONE=14) -> buzz steady high for 14 ticks, then 0. buzz_done is high from tick 15; busy is high ticks 1-14.
- pattern=3 (HALF=2, TONE=6, GAP=6, REP=3) -> three bursts, each with buzz period 4 ticks, separated by 6 silent ticks. buzz_done rises after 30 ticks total.
- abort at tick 5 of pattern 3 with simultaneous start -> buzz=0, IDLE next tick, buzz_done never set, start ignored.
- start while busy with RETRIGGER=0 -> ignored and the pattern completes unchanged. With RETRIGGER=1 -> active_pat updates and the new pattern restarts from burst 1. pattern=4 with NUM_PATTERNS=4 -> no effect.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer sequencer.
// Contents:
//   state_t     - sequencer FSM states (IDLE, TONE, GAP, DONE)
//   PAT_*       - names for the default pattern table slots, so the game FSM
//                 can request a sound by meaning rather than by index.
package buzzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned PAT_OK    = 32'd0;
  localparam int unsigned PAT_ERR   = 32'd1;
  localparam int unsigned PAT_OVER  = 32'd2;
  localparam int unsigned PAT_ALERT = 32'd3;

endpackage

// File: rtl/buzzer_tone_gen.sv
// Square-wave / steady tone generator for one buzzer channel.
// Ports:
//   tick    - clock, rising edge
//   reset   - asynchronous active-high reset (tone forced low)
//   half    - half-period in ticks; 0 means steady high
//   enable  - advance the phase counter this tick
//   clear   - restart: phase cleared and tone loaded with 'level'
//   level   - tone value loaded by clear
//   tone    - registered tone output
module buzzer_tone_gen #(
  parameter int CNT_W = 16
) (
  input  logic             tick,
  input  logic             reset,
  input  logic [CNT_W-1:0] half,
  input  logic             enable,
  input  logic             clear,
  input  logic             level,
  output logic             tone
);

  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] phase_nxt;

  // Next phase value, compared against the half-period before it is stored.
  always_comb begin
    phase_nxt = phase + CNT_W'(1);
  end

  // Phase counter and toggle flop; clear has priority over enable.
  always_ff @(posedge tick or posedge reset) begin
    if (reset) begin
      phase <= '0;
      tone  <= 1'b0;
    end else if (clear) begin
      phase <= '0;
      tone  <= level;
    end else if (enable) begin
      if (half == '0) begin
        phase <= '0;
        tone  <= 1'b1;
      end else if (phase_nxt == half) begin
        phase <= '0;
        tone  <= ~tone;
      end else begin
        phase <= phase_nxt;
      end
    end
  end

endmodule

// File: rtl/buzzer_sequencer.sv
// Table-driven buzzer pattern sequencer for the calculator game.
// A pattern is REP bursts of tone (toggled at HALF, or steady if HALF=0),
// each TONE ticks long, separated by GAP silent ticks.
// Ports:
//   tick       - clock, rising edge
//   reset      - asynchronous active-high reset
//   start      - play request, sampled each tick
//   pattern    - pattern index sampled with start
//   abort      - stop immediately, no completion reported
//   buzz       - registered buzzer drive
//   busy       - high while in TONE or GAP
//   buzz_done  - pattern completed (held or pulsed, see DONE_PULSE)
//   active_pat - pattern playing or last played
module buzzer_sequencer #(
  parameter int                          NUM_PATTERNS = 4,
  parameter int                          PAT_W        = 2,
  parameter int                          CNT_W        = 16,
  parameter logic [NUM_PATTERNS*CNT_W-1:0] HALF_TBL   = {16'd2, 16'd0, 16'd3, 16'd1},
  parameter logic [NUM_PATTERNS*CNT_W-1:0] TONE_TBL   = {16'd6, 16'd14, 16'd12, 16'd10},
  parameter logic [NUM_PATTERNS*CNT_W-1:0] GAP_TBL    = {16'd6, 16'd0, 16'd0, 16'd0},
  parameter logic [NUM_PATTERNS*CNT_W-1:0] REP_TBL    = {16'd3, 16'd1, 16'd1, 16'd1},
  parameter bit                          RETRIGGER    = 1'b0,
  parameter bit                          DONE_PULSE   = 1'b0
) (
  input  logic             tick,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic             abort,
  output logic             buzz,
  output logic             busy,
  output logic             buzz_done,
  output logic [PAT_W-1:0] active_pat
);

  import buzzer_pkg::*;

  state_t           state;
  logic [CNT_W-1:0] half_len, tone_len, gap_len, rep_len;
  logic [CNT_W-1:0] tone_cnt, gap_cnt, burst_cnt;

  logic             in_range, accept;
  int unsigned      pat_idx;
  logic [CNT_W-1:0] sel_half, sel_tone, sel_gap, sel_rep;
  logic [CNT_W-1:0] tone_nxt, gap_nxt;
  logic             tone_end, gap_end, last_burst;
  logic             gen_en, gen_clear, gen_level;

  // Zero table entries that would stall the FSM are lifted to one tick.
  function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // Start acceptance and table lookup (index forced to 0 when out of range
  // so the part-select never leaves the table).
  always_comb begin
    in_range = ({{(32-PAT_W){1'b0}}, pattern} < 32'(NUM_PATTERNS));
    if (in_range) begin
      pat_idx = 32'(pattern);
    end else begin
      pat_idx = 32'd0;
    end
    accept   = start && in_range &&
               (RETRIGGER || (state == ST_IDLE) || (state == ST_DONE));
    sel_half = HALF_TBL[pat_idx*CNT_W +: CNT_W];
    sel_tone = TONE_TBL[pat_idx*CNT_W +: CNT_W];
    sel_gap  = GAP_TBL[pat_idx*CNT_W +: CNT_W];
    sel_rep  = REP_TBL[pat_idx*CNT_W +: CNT_W];
  end

  // Burst/gap end detection: equality is tested on the incremented value,
  // so counters never run past their limit.
  always_comb begin
    tone_nxt   = tone_cnt + CNT_W'(1);
    gap_nxt    = gap_cnt + CNT_W'(1);
    tone_end   = (tone_nxt == tone_len);
    gap_end    = (gap_nxt == gap_len);
    last_burst = (burst_cnt == rep_len);
  end

  // Tone generator control, mirroring the FSM decisions below. A zero gap
  // is stored as one tick, which gives the single silent tick between
  // back-to-back bursts.
  always_comb begin
    gen_en    = 1'b0;
    gen_clear = 1'b0;
    gen_level = 1'b0;
    if (abort) begin
      gen_clear = 1'b1;
    end else if (accept) begin
      gen_clear = 1'b1;
      gen_level = 1'b1;
    end else begin
      case (state)
        ST_TONE: begin
          if (tone_end) begin
            gen_clear = 1'b1;
          end else begin
            gen_en = 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            gen_clear = 1'b1;
            gen_level = 1'b1;
          end else begin
            gen_en = 1'b0;
          end
        end
        default: begin
          gen_en = 1'b0;
        end
      endcase
    end
  end

  buzzer_tone_gen #(.CNT_W(CNT_W)) u_tone_gen (
    .tick   (tick),
    .reset  (reset),
    .half   (half_len),
    .enable (gen_en),
    .clear  (gen_clear),
    .level  (gen_level),
    .tone   (buzz)
  );

  // Sequencer FSM: abort beats start, start beats normal progress.
  always_ff @(posedge tick or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      buzz_done  <= 1'b0;
      active_pat <= '0;
      half_len   <= '0;
      tone_len   <= '0;
      gap_len    <= '0;
      rep_len    <= '0;
      tone_cnt   <= '0;
      gap_cnt    <= '0;
      burst_cnt  <= '0;
    end else if (abort) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      buzz_done <= 1'b0;
      tone_cnt  <= '0;
      gap_cnt   <= '0;
      burst_cnt <= '0;
    end else if (accept) begin
      state      <= ST_TONE;
      busy       <= 1'b1;
      buzz_done  <= 1'b0;
      active_pat <= pattern;
      half_len   <= sel_half;
      tone_len   <= at_least_one(sel_tone);
      gap_len    <= at_least_one(sel_gap);
      rep_len    <= at_least_one(sel_rep);
      tone_cnt   <= '0;
      gap_cnt    <= '0;
      burst_cnt  <= CNT_W'(1);
    end else begin
      case (state)
        ST_TONE: begin
          if (tone_end) begin
            tone_cnt <= '0;
            gap_cnt  <= '0;
            if (last_burst) begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              buzz_done <= 1'b1;
            end else begin
              state <= ST_GAP;
            end
          end else begin
            tone_cnt <= tone_nxt;
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            state     <= ST_TONE;
            gap_cnt   <= '0;
            tone_cnt  <= '0;
            burst_cnt <= burst_cnt + CNT_W'(1);
          end else begin
            gap_cnt <= gap_nxt;
          end
        end
        ST_DONE: begin
          if (DONE_PULSE) begin
            state     <= ST_IDLE;
            buzz_done <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed self-checking bench for buzzer_sequencer.
// dut_a: default tables, PAT_W=3 (so index 4..7 can be driven), no retrigger,
//        held buzz_done.  dut_b: default tables, retrigger, pulsed buzz_done.
module tb_buzzer_sequencer;

  logic       clk;
  logic       rst;
  logic       a_start, a_abort, b_start, b_abort;
  logic [2:0] a_pattern;
  logic [1:0] b_pattern;
  logic       a_buzz, a_busy, a_done, b_buzz, b_busy, b_done;
  logic [2:0] a_active;
  logic [1:0] b_active;

  int n_checks = 0;
  int n_pass   = 0;

  buzzer_sequencer #(.NUM_PATTERNS(4), .PAT_W(3), .RETRIGGER(1'b0), .DONE_PULSE(1'b0)) dut_a (
    .tick(clk), .reset(rst), .start(a_start), .pattern(a_pattern), .abort(a_abort),
    .buzz(a_buzz), .busy(a_busy), .buzz_done(a_done), .active_pat(a_active)
  );

  buzzer_sequencer #(.NUM_PATTERNS(4), .PAT_W(2), .RETRIGGER(1'b1), .DONE_PULSE(1'b1)) dut_b (
    .tick(clk), .reset(rst), .start(b_start), .pattern(b_pattern), .abort(b_abort),
    .buzz(b_buzz), .busy(b_busy), .buzz_done(b_done), .active_pat(b_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one tick; outputs are then sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected buzz of pattern 3 (HALF=2, TONE=6, GAP=6, REP=3) at tick k.
  function automatic int p3_buzz(input int k);
    int w;
    w = (k - 1) % 12;
    if (k > 30) return 0;
    if (w < 6) return ((w % 4) < 2) ? 1 : 0;
    return 0;
  endfunction

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_pattern = 3'd0;
    b_start = 1'b0; b_abort = 1'b0; b_pattern = 2'd0;
    @(negedge clk);
    check("rst_buzz", int'(a_buzz), 0);
    check("rst_busy", int'(a_busy), 0);
    check("rst_done", int'(a_done), 0);
    check("rst_active", int'(a_active), 0);
    rst = 1'b0;
    step();

    // ---- dut_b: retrigger pattern 3 -> pattern 0 at tick 4 ----
    b_start = 1'b1; b_pattern = 2'd3; step(); b_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      check("b_p3_buzz", int'(b_buzz), p3_buzz(k));
      if (k == 4) begin
        b_start = 1'b1; b_pattern = 2'd0;
      end
      step();
    end
    b_start = 1'b0;
    check("b_retrig_active", int'(b_active), 0);
    for (int k = 1; k <= 12; k++) begin
      check("b_p0_buzz", int'(b_buzz), (k <= 10) ? (k % 2) : 0);
      check("b_p0_busy", int'(b_busy), (k <= 10) ? 1 : 0);
      check("b_p0_done", int'(b_done), (k == 11) ? 1 : 0);
      step();
    end

    // ---- dut_b: completion and start in the same tick -> start wins ----
    b_start = 1'b1; b_pattern = 2'd0; step(); b_start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check("b_p0b_buzz", int'(b_buzz), k % 2);
      if (k == 10) begin
        b_start = 1'b1; b_pattern = 2'd2;
      end
      step();
    end
    b_start = 1'b0;
    check("b_collide_active", int'(b_active), 2);
    for (int k = 1; k <= 16; k++) begin
      check("b_p2_buzz", int'(b_buzz), (k <= 14) ? 1 : 0);
      check("b_p2_busy", int'(b_busy), (k <= 14) ? 1 : 0);
      check("b_p2_done", int'(b_done), (k == 15) ? 1 : 0);
      step();
    end

    // ---- dut_a: pattern 0, toggle every tick, done held ----
    a_start = 1'b1; a_pattern = 3'd0; step(); a_start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      check("a_p0_buzz", int'(a_buzz), (k <= 10) ? (k % 2) : 0);
      check("a_p0_busy", int'(a_busy), (k <= 10) ? 1 : 0);
      check("a_p0_done", int'(a_done), (k >= 11) ? 1 : 0);
      step();
    end

    // ---- dut_a: pattern 2, steady; a start at tick 5 is ignored ----
    a_start = 1'b1; a_pattern = 3'd2; step(); a_start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      check("a_p2_buzz", int'(a_buzz), (k <= 14) ? 1 : 0);
      check("a_p2_busy", int'(a_busy), (k <= 14) ? 1 : 0);
      check("a_p2_done", int'(a_done), (k >= 15) ? 1 : 0);
      check("a_p2_active", int'(a_active), 2);
      a_start = (k == 5) ? 1'b1 : 1'b0;
      a_pattern = 3'd3;
      step();
    end
    a_start = 1'b0;

    // ---- dut_a: pattern 3, three bursts with gaps ----
    a_start = 1'b1; a_pattern = 3'd3; step(); a_start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      check("a_p3_buzz", int'(a_buzz), p3_buzz(k));
      check("a_p3_busy", int'(a_busy), (k <= 30) ? 1 : 0);
      check("a_p3_done", int'(a_done), (k >= 31) ? 1 : 0);
      step();
    end

    // ---- dut_a: out-of-range indices leave DONE untouched ----
    a_start = 1'b1; a_pattern = 3'd4; step();
    a_pattern = 3'd7; step();
    a_start = 1'b0;
    check("a_oor_done", int'(a_done), 1);
    check("a_oor_busy", int'(a_busy), 0);
    check("a_oor_buzz", int'(a_buzz), 0);
    check("a_oor_active", int'(a_active), 3);

    // ---- dut_a: abort at tick 5 of pattern 3 with simultaneous start ----
    a_start = 1'b1; a_pattern = 3'd3; step(); a_start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check("a_ab_buzz", int'(a_buzz), p3_buzz(k));
      if (k < 5) step();
    end
    a_abort = 1'b1; a_start = 1'b1; a_pattern = 3'd0; step();
    a_abort = 1'b0; a_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("a_ab_buzz0", int'(a_buzz), 0);
      check("a_ab_busy", int'(a_busy), 0);
      check("a_ab_done", int'(a_done), 0);
      check("a_ab_active", int'(a_active), 3);
      step();
    end

    // ---- dut_a: asynchronous reset in the middle of a TONE ----
    a_start = 1'b1; a_pattern = 3'd0; step(); a_start = 1'b0;
    step(); step();
    check("a_pre_rst_buzz", int'(a_buzz), 1);
    #2 rst = 1'b1;
    #1;
    check("a_async_buzz", int'(a_buzz), 0);
    check("a_async_busy", int'(a_busy), 0);
    check("a_async_done", int'(a_done), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("a_post_rst_busy", int'(a_busy), 0);
    check("a_post_rst_active", int'(a_active), 0);
    a_start = 1'b1; a_pattern = 3'd2; step(); a_start = 1'b0;
    check("a_restart_buzz", int'(a_buzz), 1);
    check("a_restart_busy", int'(a_busy), 1);
    check("a_restart_active", int'(a_active), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
